param_updown_counter: RTL and testbench

//  Parametrised successor to the team's 8-bit free-running up counter.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/param_updown_counter.sv | 66 ++++++
 tb/tb_param_updown_counter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter: mode constants and
// the width-agnostic step function used by the counter's next-state logic.
package counter_pkg;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Returns {boundary, next}; operands are zero-extended to 32 bits by the caller.
    function automatic logic [32:0] next_count(
        input logic [31:0] val,
        input logic        up,
        input logic [31:0] max,
        input logic        sat
    );
        logic [32:0] res;
        res = '0;
        if (up) begin
            if (val == max) res = {1'b1, (sat ? max : 32'd0)};
            else            res = {1'b0, val + 32'd1};
        end else begin
            if (val == 32'd0) res = {1'b1, (sat ? 32'd0 : max)};
            else              res = {1'b0, val - 32'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap/saturate modes, terminal-count, wrap pulse and sticky overflow flag.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
    parameter logic             SATURATE  = CNT_WRAP,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [31:0] MAX32 = 32'(MAX_VALUE);

    logic [32:0]      step;
    logic [WIDTH-1:0] step_val;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;

    assign step     = next_count(32'(count), up, MAX32, SATURATE);
    assign step_val = step[WIDTH-1:0];
    assign boundary = step[32];

    // Bits above WIDTH are always zero because every operand fits in WIDTH bits.
    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^step[31:WIDTH];
        end
    endgenerate

    assign load_clamped = (load_val > MAX_VALUE) ? MAX_VALUE : load_val;

    assign tc = en & (up ? (count == MAX_VALUE) : (count == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VAL;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_clamped;
            end else if (en) begin
                count <= step_val;
                wrap  <= boundary;
            end
            // A boundary event outranks a simultaneous clear.
            if (en && !load && boundary) ovf <= 1'b1;
            else if (clr_ovf)            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three instances (8-bit wrap, modulus 10,
// 8-bit saturate) share stimulus and are checked against a behavioural scoreboard.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, load, clr_ovf;
    logic [7:0] load_val;

    logic [7:0] cnt0, cnt1, cnt2;
    logic [2:0] tcv, wrv, ovv;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt  [3];
    int m_wrap [3];
    int m_ovf  [3];
    int maxv   [3];
    int satv   [3];

    logic [29:0] sb [$];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(8)) d0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(cnt0), .tc(tcv[0]), .wrap(wrv[0]), .ovf(ovv[0]));
    param_updown_counter #(.WIDTH(8), .MAX_VALUE(8'd9)) d1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(cnt1), .tc(tcv[1]), .wrap(wrv[1]), .ovf(ovv[1]));
    param_updown_counter #(.WIDTH(8), .SATURATE(1'b1)) d2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(cnt2), .tc(tcv[2]), .wrap(wrv[2]), .ovf(ovv[2]));

    function automatic logic [9:0] actual(input int i);
        logic [7:0] c;
        c = (i == 0) ? cnt0 : (i == 1) ? cnt1 : cnt2;
        return {ovv[i], wrv[i], c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // One clock of stimulus: check tc before the edge, push the model's
    // post-edge state, then pop and compare once the DUTs have updated.
    task automatic tick(input logic e, input logic u, input logic l,
                        input logic [7:0] lv, input logic c);
        logic [29:0] exp_all;
        logic [9:0]  e_i, a_i;
        int          bnd;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv; clr_ovf = c;
        #1;
        for (int i = 0; i < 3; i++) begin
            logic exp_tc;
            exp_tc = e && (u ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0));
            n_checks++;
            if (tcv[i] !== exp_tc) begin
                n_fail++;
                $display("FAIL tc[%0d]: got %b expected %b (count model %0d)", i, tcv[i], exp_tc, m_cnt[i]);
            end
        end
        exp_all = '0;
        for (int i = 0; i < 3; i++) begin
            if (l) begin
                m_cnt[i]  = (int'(lv) > maxv[i]) ? maxv[i] : int'(lv);
                m_wrap[i] = 0;
                if (c) m_ovf[i] = 0;
            end else if (e) begin
                bnd = u ? int'(m_cnt[i] == maxv[i]) : int'(m_cnt[i] == 0);
                if (u) m_cnt[i] = bnd != 0 ? (satv[i] != 0 ? maxv[i] : 0) : m_cnt[i] + 1;
                else   m_cnt[i] = bnd != 0 ? (satv[i] != 0 ? 0 : maxv[i]) : m_cnt[i] - 1;
                m_wrap[i] = bnd;
                if (bnd != 0) m_ovf[i] = 1;
                else if (c)   m_ovf[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (c) m_ovf[i] = 0;
            end
            exp_all[i*10 +: 10] = {m_ovf[i][0], m_wrap[i][0], m_cnt[i][7:0]};
        end
        sb.push_back(exp_all);
        @(posedge clk);
        #1;
        exp_all = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            e_i = exp_all[i*10 +: 10];
            a_i = actual(i);
            n_checks++;
            if (a_i !== e_i) begin
                n_fail++;
                $display("FAIL state[%0d] {ovf,wrap,count}: got %b/%b/%h expected %b/%b/%h",
                         i, a_i[9], a_i[8], a_i[7:0], e_i[9], e_i[8], e_i[7:0]);
            end
        end
        en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cnt0, cnt1, cnt2, wrv, ovv} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h %h %h wrap %b ovf %b expected all zero", cnt0, cnt1, cnt2, wrv, ovv);
        end
        tick(1'b0, 1'b1, 1'b1, 8'h36, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (cnt0 !== 8'h37 || ovv[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got count %h ovf1 %b expected 37 / 1", cnt0, ovv[1]);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({cnt0, cnt1, cnt2, ovv, wrv} !== 30'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h %h %h ovf %b wrap %b expected all zero", cnt0, cnt1, cnt2, ovv, wrv);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (cnt0 !== 8'h01) begin
            n_fail++;
            $display("FAIL resume_after_reset: got %h expected 01", cnt0);
        end
    endtask

    task automatic test_wrap_256();
        int wraps = 0;
        tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
        for (int k = 0; k < 256; k++) begin
            tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            if (wrv[0] === 1'b1) wraps++;
        end
        n_checks++;
        if (cnt0 !== 8'h00 || wraps != 1 || ovv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_256: got count %h wraps %0d ovf %b expected 00 / 1 / 1", cnt0, wraps, ovv[0]);
        end
    endtask

    task automatic test_mod9_down();
        int wraps = 0;
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            int exp_c;
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            exp_c = (k == 11) ? 9 : 10 - k;
            if (wrv[1] === 1'b1) wraps++;
            n_checks++;
            if (int'(cnt1) != exp_c || ovv[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL mod9_down step %0d: got %0d ovf %b expected %0d ovf 1", k, cnt1, ovv[1], exp_c);
            end
        end
        n_checks++;
        if (wraps != 2) begin
            n_fail++;
            $display("FAIL mod9_wrap_pulses: got %0d expected 2", wraps);
        end
    endtask

    task automatic test_saturate();
        tick(1'b0, 1'b1, 1'b1, 8'hFE, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            n_checks++;
            if (cnt2 !== 8'hFF || wrv[2] !== (k >= 2)) begin
                n_fail++;
                $display("FAIL saturate edge %0d: got count %h wrap %b expected ff wrap %b", k, cnt2, wrv[2], k >= 2);
            end
        end
    endtask

    task automatic test_load_priority();
        tick(1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
        n_checks++;
        if (cnt0 !== 8'h20) begin
            n_fail++;
            $display("FAIL load_over_en: got %h expected 20", cnt0);
        end
        tick(1'b0, 1'b1, 1'b1, 8'd15, 1'b0);
        n_checks++;
        if (cnt1 !== 8'd9) begin
            n_fail++;
            $display("FAIL load_clamp: got %0d expected 9", cnt1);
        end
    endtask

    task automatic test_clr_ovf();
        tick(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (ovv[0] !== 1'b1 || wrv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_event: got ovf %b wrap %b expected 1 / 1", ovv[0], wrv[0]);
        end
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (ovv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovf: got %b expected 0", ovv[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            tick(r != 4'd0, 1'($urandom), r == 4'd15, 8'($urandom), r == 4'd7);
        end
    endtask

    initial begin
        maxv[0] = 255; maxv[1] = 9; maxv[2] = 255;
        satv[0] = 0;   satv[1] = 0; satv[2] = 1;
        model_reset();
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap_256();
        test_mod9_down();
        test_saturate();
        test_load_priority();
        test_clr_ovf();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
